// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default qualification length.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } state_t;

    // 10 ms at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; reusable for any
// external input that must be brought into the CLOCK domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], D};
    end

    assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level into a clean registered level plus one-cycle
// rise/fall pulses; the clean level drives the D input of the downstream flop.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic BTN_IN,
    output logic BTN_CLEAN,
    output logic RISE_PULSE,
    output logic FALL_PULSE,
    output logic BUSY
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_in;
    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 clean_n, rise_n, fall_n, busy_n;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .D      (BTN_IN),
        .Q      (sync_in)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= STABLE_LOW;
            cnt        <= '0;
            BTN_CLEAN  <= 1'b0;
            RISE_PULSE <= 1'b0;
            FALL_PULSE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            BTN_CLEAN  <= clean_n;
            RISE_PULSE <= rise_n;
            FALL_PULSE <= fall_n;
            BUSY       <= busy_n;
        end
    end

    // Any disagreeing sample inside a CHECK state drops back to the stable
    // state, so the count always restarts from zero after a bounce.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        clean_n = BTN_CLEAN;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        unique case (state)
            STABLE_LOW: begin
                if (sync_in) state_n = CHECK_HIGH;
            end
            CHECK_HIGH: begin
                if (!sync_in) begin
                    state_n = STABLE_LOW;
                end else if (cnt == CNT_MAX) begin
                    state_n = STABLE_HIGH;
                    clean_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) state_n = CHECK_LOW;
            end
            CHECK_LOW: begin
                if (sync_in) begin
                    state_n = STABLE_HIGH;
                end else if (cnt == CNT_MAX) begin
                    state_n = STABLE_LOW;
                    clean_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            default: state_n = STABLE_LOW;
        endcase
        busy_n = (state_n == CHECK_HIGH) || (state_n == CHECK_LOW);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: timing of press/release, bounce and
// glitch rejection, async reset abort and a long-count instance.
module tb_button_debouncer;

    logic CLOCK = 1'b0;
    logic RESET_N = 1'b0;
    logic btn = 1'b0;
    logic clean, rise, fall, busy;
    logic btn2 = 1'b0;
    logic clean2, rise2, fall2, busy2;

    int checks = 0;
    int failures = 0;

    always #5 CLOCK = ~CLOCK;

    button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_IN(btn),
        .BTN_CLEAN(clean), .RISE_PULSE(rise), .FALL_PULSE(fall), .BUSY(busy)
    );

    button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1000)) dut2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .BTN_IN(btn2),
        .BTN_CLEAN(clean2), .RISE_PULSE(rise2), .FALL_PULSE(fall2), .BUSY(busy2)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        RESET_N = 1'b0;
        btn = 1'b0;
        repeat (3) tick();
        obs = {clean, rise, fall, busy};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: got %b expected 0000", obs);
        end
        RESET_N = 1'b1;
        repeat (3) tick();
        obs = {clean, rise, fall, busy};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle: got %b expected 0000", obs);
        end
    endtask

    // Press from STABLE_LOW with the input held: busy after edges 3..10, rise at 11.
    task automatic test_clean_press(input string name);
        logic [3:0] obs, exp;
        btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            obs = {clean, rise, fall, busy};
            exp = {e >= 11, e == 11, 1'b0, (e >= 3 && e <= 10)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s edge %0d: got %b expected %b", name, e, obs, exp);
            end
        end
    endtask

    task automatic test_clean_release();
        logic [3:0] obs, exp;
        btn = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            obs = {clean, rise, fall, busy};
            exp = {e < 11, 1'b0, e == 11, (e >= 3 && e <= 10)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL release edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // High for edges 1..5, low at 6, high from 7: first check aborts after
    // edge 8, requalifies from edge 9, rise after edge 17.
    task automatic test_bounce();
        logic [3:0] obs, exp;
        int rises = 0;
        for (int e = 1; e <= 20; e++) begin
            btn = (e != 6);
            tick();
            obs = {clean, rise, fall, busy};
            exp = {e >= 17, e == 17, 1'b0, ((e >= 3 && e <= 7) || (e >= 9 && e <= 16))};
            if (rise) rises++;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bounce edge %0d: got %b expected %b", e, obs, exp);
            end
        end
        checks++;
        if (rises !== 1) begin
            failures++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", rises);
        end
        btn = 1'b0;
        repeat (15) tick();
        checks++;
        if ({clean, busy} !== 2'b00) begin
            failures++;
            $display("FAIL bounce_return_low: got %b expected 00", {clean, busy});
        end
    endtask

    // High for edges 1..6 only: busy after edges 3..8, never accepted.
    task automatic test_short_glitch();
        logic [3:0] obs, exp;
        for (int e = 1; e <= 16; e++) begin
            btn = (e <= 6);
            tick();
            obs = {clean, rise, fall, busy};
            exp = {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 8)};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL glitch edge %0d: got %b expected %b", e, obs, exp);
            end
        end
    endtask

    // Abort a press at counter 4 (after edge 7), then requalify the held input.
    task automatic test_reset_mid();
        logic [3:0] obs;
        btn = 1'b1;
        repeat (7) tick();
        checks++;
        if ({clean, busy} !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_pre: got %b expected 01", {clean, busy});
        end
        RESET_N = 1'b0;
        #1;
        obs = {clean, rise, fall, busy};
        checks++;
        if (obs !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async: got %b expected 0000", obs);
        end
        tick();
        RESET_N = 1'b1;
        test_clean_press("rstmid_requal");
    endtask

    task automatic test_long_count();
        int max_cnt = 0;
        btn2 = 1'b1;
        for (int e = 1; e <= 1010; e++) begin
            tick();
            if (int'(dut2.cnt) > max_cnt) max_cnt = int'(dut2.cnt);
            if (e == 1002 || e == 1003 || e == 1004) begin
                checks++;
                if ({clean2, rise2} !== {e >= 1003, e == 1003}) begin
                    failures++;
                    $display("FAIL long edge %0d: got %b expected %b", e,
                             {clean2, rise2}, {e >= 1003, e == 1003});
                end
            end
        end
        checks++;
        if (max_cnt !== 999) begin
            failures++;
            $display("FAIL long_max_cnt: got %0d expected 999", max_cnt);
        end
    endtask

    // Rise and fall must never coincide on either instance.
    always @(negedge CLOCK) begin
        if (RESET_N && ((rise && fall) || (rise2 && fall2))) begin
            failures++;
            $display("FAIL pulse_exclusive at %0t", $time);
        end
    end

    initial begin
        test_reset();
        test_clean_press("press");
        test_clean_release();
        test_bounce();
        test_short_glitch();
        test_reset_mid();
        btn = 1'b0;
        repeat (15) tick();
        test_long_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
